prim_sync_reqack_arb: RTL and testbench
=======================================

# prim_sync_reqack_arb

Round-robin arbiter that shares one REQ/ACK clock-domain-crossing synchronizer (NRZ or RZ variant) between `NumReq` requesters in the source clock domain. It selects one pending requester, latches that requester's payload and index, and holds the synchronizer's source-side REQ until the ACK returns. It then forwards the one-cycle ACK to the granted requester and advances the round-robin pointer. A watchdog flags handshakes that never complete. The block sits directly in front of the synchronizer's SRC-side `src_req_i`/`src_ack_o` pins.

## Interface
- `NumReq`, default 4: number of requesters; legal range 2..16.
- `DataW`, default 8: payload width per requester.
- `TimeoutCycles`, default 1024: BUSY-cycle limit before the watchdog error. 0 disables the watchdog.
- `IdxW`, derived, `$clog2(NumReq)`: width of the grant index.

- `clk_src_i`  in  1  source-domain clock.
- `rst_src_ni`  in  1  reset, asynchronous, active-low; clock `clk_src_i`.
- `req_i`  in  NumReq  per-requester request. Must be held until the matching `ack_o` bit.
- `data_i`  in  NumReq*DataW  per-requester payload. Slice i is `data_i[i*DataW +: DataW]`.
- `ack_o`  out  NumReq  one-cycle completion pulse to the granted requester.
- `sync_req_o`  out  1  REQ to the synchronizer SRC side.
- `sync_ack_i`  in  1  ACK from the synchronizer SRC side (one-cycle pulse).
- `sync_data_o`  out  DataW  latched payload. Stable for the whole time `sync_req_o` is high.
- `sync_idx_o`  out  IdxW  latched index of the granted requester.
- `busy_o`  out  1  high while a handshake is outstanding.
- `err_timeout_o`  out  1  sticky watchdog error.

## Operation
- The FSM has two states, IDLE and BUSY. Reset state is IDLE.
- IDLE behaviour:
  - If any `req_i` bit is high, select the first set bit searching upward from `rr_q` and wrapping modulo NumReq.
  - On the same edge, latch the selected index into `sync_idx_o`, its payload slice into `sync_data_o`, and go to BUSY.
  - If no request is pending, stay in IDLE; outputs hold their last values.
- BUSY behaviour:
  - `sync_req_o` = 1 and `busy_o` = 1.
  - The latched data and index are frozen.
  - `sync_ack_i` = 1 causes two things:
    - `ack_o[sync_idx_o]` = 1 combinationally in the same cycle.
    - At the next edge: state goes to IDLE, and `rr_q` becomes `(sync_idx_o + 1)`, wrapping to 0 when the result equals NumReq.
- `sync_req_o` is a function of state only. It never drops before `sync_ack_i`, which satisfies the synchronizer's hold-REQ rule even if the granted `req_i` falls early (a protocol violation, which is ignored).
- `sync_ack_i` while IDLE is illegal. It is ignored: no `ack_o`, no state change.
- `req_i` changes during BUSY are not sampled. New or withdrawn requests only take effect in the next IDLE cycle.
- Watchdog:
  - Counter `to_q` clears on entry to BUSY and increments each BUSY cycle, saturating at `TimeoutCycles`.
  - When `to_q` reaches `TimeoutCycles`, `err_timeout_o` is set and stays set until reset.
  - The handshake is not aborted; BUSY continues waiting.
  - With `TimeoutCycles` = 0, the counter is not built and `err_timeout_o` is tied 0.
- Reset values: `ack_o` = 0, `sync_req_o` = 0, `sync_data_o` = 0, `sync_idx_o` = 0, `busy_o` = 0, `err_timeout_o` = 0, `rr_q` = 0, `to_q` = 0.
- Reset mid-handshake returns the block to IDLE immediately. The DST side of the synchronizer must be reset in the same window; that is a system-level rule and is not checked here.

## Timing
- Grant latency: `req_i` high before edge k gives `sync_req_o`/`busy_o` high after edge k.
- Completion: `sync_ack_i` high in cycle m gives `ack_o` high in cycle m, and `sync_req_o` low after edge m+1.
- Back-to-back handshakes: the next grant is latched at edge m+2 at the earliest, because at least one IDLE cycle sits between handshakes.
- Maximum throughput is one handshake per (synchronizer round trip + 2) source cycles.
- The watchdog sets `err_timeout_o` after edge `TimeoutCycles` counted from BUSY entry, i.e. on the TimeoutCycles-th BUSY cycle with no ACK.
- `ack_o` is one-hot or zero in every cycle.

## Test plan
- Single requester: NumReq=4, `req_i`=4'b0100, `data_i` slice2=8'hA5, ACK 6 cycles later.
  - Expect `sync_req_o` high after 1 edge, `sync_idx_o`=2, `sync_data_o`=A5.
  - Expect `ack_o`=4'b0100 for exactly 1 cycle, then `rr_q`=3.
- Round-robin fairness: `req_i`=4'b1111 held, each requester dropping its own request on its ACK.
  - Expect grant order 0,1,2,3.
  - Restart with `rr_q`=3: expect order 3,0,1,2.
- Wrap with NumReq=3: grant index 2 completes.
  - Expect `rr_q`=0, never 3.
- Early request drop and stray ACK:
  - Drop `req_i` of the granted requester mid-BUSY: expect `sync_req_o` held high and `sync_data_o` unchanged until ACK.
  - Pulse `sync_ack_i` in IDLE: expect no `ack_o` and no state change.
- Watchdog: TimeoutCycles=8, no ACK.
  - Expect `err_timeout_o`=1 on the 8th BUSY cycle, `sync_req_o` still 1.
  - A late ACK completes normally; `err_timeout_o` stays 1 until reset.
- Async reset asserted mid-BUSY: all outputs 0 immediately.
  - After release, a pending `req_i`=4'b0010 is granted at the first edge with `sync_idx_o`=1.

Source files
------------

// File: rtl/prim_sync_reqack_arb_if.sv
// Handshake bundle between the requesters, the round-robin arbiter and the
// SRC side of a REQ/ACK synchronizer.
interface prim_sync_reqack_arb_if #(
    parameter int NumReq = 4,
    parameter int DataW  = 8
);
    localparam int IdxW = $clog2(NumReq);

    logic [NumReq-1:0]       req_i;
    logic [NumReq*DataW-1:0] data_i;
    logic [NumReq-1:0]       ack_o;
    logic                    sync_req_o;
    logic                    sync_ack_i;
    logic [DataW-1:0]        sync_data_o;
    logic [IdxW-1:0]         sync_idx_o;
    logic                    busy_o;
    logic                    err_timeout_o;

    // Arbiter side
    modport slave (
        input  req_i, data_i, sync_ack_i,
        output ack_o, sync_req_o, sync_data_o, sync_idx_o, busy_o, err_timeout_o
    );

    // Requester / synchronizer side
    modport master (
        output req_i, data_i, sync_ack_i,
        input  ack_o, sync_req_o, sync_data_o, sync_idx_o, busy_o, err_timeout_o
    );
endinterface

// File: rtl/prim_sync_reqack_arb.sv
// Round-robin arbiter sharing one REQ/ACK synchronizer between NumReq
// source-domain requesters, with an optional sticky handshake watchdog.
module prim_sync_reqack_arb #(
    parameter int NumReq        = 4,
    parameter int DataW         = 8,
    parameter int TimeoutCycles = 1024
) (
    input logic                   clk_src_i,
    input logic                   rst_src_ni,
    prim_sync_reqack_arb_if.slave bus
);
    localparam int IdxW = $clog2(NumReq);

    typedef enum logic {Idle, Busy} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   rr_q;
    logic [IdxW-1:0]   idx_q;
    logic [DataW-1:0]  data_q;
    logic              sel_vld;
    logic [IdxW-1:0]   sel_idx;
    logic              start;
    logic              done;

    // Pick the first pending request at or above rr_q, wrapping modulo NumReq
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NumReq; k++) begin
            int c;
            c = int'(rr_q) + k;
            if (c >= NumReq) c = c - NumReq;
            if (!sel_vld && bus.req_i[c]) begin
                sel_vld = 1'b1;
                sel_idx = IdxW'(c);
            end
        end
    end

    assign start = (state_q == Idle) && sel_vld;
    assign done  = (state_q == Busy) && bus.sync_ack_i;

    // Grant FSM: latch index/payload on grant, release and advance pointer on ACK
    always_ff @(posedge clk_src_i or negedge rst_src_ni) begin
        if (!rst_src_ni) begin
            state_q <= Idle;
            rr_q    <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                Idle: if (sel_vld) begin
                    state_q <= Busy;
                    idx_q   <= sel_idx;
                    data_q  <= bus.data_i[int'(sel_idx)*DataW +: DataW];
                end
                Busy: if (bus.sync_ack_i) begin
                    state_q <= Idle;
                    rr_q    <= (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + 1'b1;
                end
                default: state_q <= Idle;
            endcase
        end
    end

    // Completion pulse routed to the granted requester; stray ACKs in Idle are dropped
    always_comb begin
        bus.ack_o = '0;
        if (done) bus.ack_o[idx_q] = 1'b1;
    end

    assign bus.sync_req_o  = (state_q == Busy);
    assign bus.busy_o      = (state_q == Busy);
    assign bus.sync_idx_o  = idx_q;
    assign bus.sync_data_o = data_q;

    if (TimeoutCycles > 0) begin : g_wd
        localparam int ToW = $clog2(TimeoutCycles + 1);
        logic [ToW-1:0] to_q, to_d;
        logic           err_q;

        // to_q holds the number of BUSY cycles so far including the current one,
        // so the error shows up on the TimeoutCycles-th BUSY cycle.
        always_comb begin
            to_d = to_q;
            if (start)                                            to_d = ToW'(1);
            else if (bus.busy_o && !done && to_q != ToW'(TimeoutCycles)) to_d = to_q + 1'b1;
        end

        // Saturating BUSY counter and sticky error flag
        always_ff @(posedge clk_src_i or negedge rst_src_ni) begin
            if (!rst_src_ni) begin
                to_q  <= '0;
                err_q <= 1'b0;
            end else begin
                to_q <= to_d;
                if (to_d == ToW'(TimeoutCycles) && (start || bus.busy_o)) err_q <= 1'b1;
            end
        end

        assign bus.err_timeout_o = err_q;
    end else begin : g_no_wd
        assign bus.err_timeout_o = 1'b0;
    end
endmodule

// File: tb/tb_prim_sync_reqack_arb.sv
module tb_prim_sync_reqack_arb;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    prim_sync_reqack_arb_if #(.NumReq(4), .DataW(8)) ba ();
    prim_sync_reqack_arb_if #(.NumReq(3), .DataW(8)) bb ();

    prim_sync_reqack_arb #(.NumReq(4), .DataW(8), .TimeoutCycles(8)) dut_a (
        .clk_src_i (clk),
        .rst_src_ni(rst_n),
        .bus       (ba)
    );

    prim_sync_reqack_arb #(.NumReq(3), .DataW(8), .TimeoutCycles(0)) dut_b (
        .clk_src_i (clk),
        .rst_src_ni(rst_n),
        .bus       (bb)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            n_tests++;
            if ((ba.ack_o & (ba.ack_o - 4'd1)) !== 4'd0) begin
                n_fail++;
                $error("FAIL onehot_a: ack_o=%b", ba.ack_o);
            end
            if ((bb.ack_o & (bb.ack_o - 3'd1)) !== 3'd0) begin
                n_fail++;
                $error("FAIL onehot_b: ack_o=%b", bb.ack_o);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    `define CHK(t, o, e) check(t, 32'(o), 32'(e))

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hs(input int exp_idx, input logic [7:0] exp_data);
        tick();
        `CHK("hs_idx",  ba.sync_idx_o, exp_idx);
        `CHK("hs_data", ba.sync_data_o, exp_data);
        `CHK("hs_req",  ba.sync_req_o, 1);
        tick();
        ba.sync_ack_i = 1'b1;
        #1;
        `CHK("hs_ack", ba.ack_o, 4'b0001 << exp_idx);
        tick();
        ba.sync_ack_i = 1'b0;
        ba.req_i[exp_idx] = 1'b0;
        #1;
        `CHK("hs_ack_clr", ba.ack_o, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ba.req_i = '0; ba.data_i = '0; ba.sync_ack_i = 1'b0;
        bb.req_i = '0; bb.data_i = '0; bb.sync_ack_i = 1'b0;
        #1;
        `CHK("rst_sync_req", ba.sync_req_o, 0);
        `CHK("rst_busy",     ba.busy_o, 0);
        `CHK("rst_idx",      ba.sync_idx_o, 0);
        `CHK("rst_data",     ba.sync_data_o, 0);
        `CHK("rst_err",      ba.err_timeout_o, 0);
        `CHK("rst_ack",      ba.ack_o, 0);
        #11 rst_n = 1'b1;

        ba.data_i = {8'h33, 8'hA5, 8'h22, 8'h11};
        ba.req_i  = 4'b0100;
        tick();
        `CHK("t1_sync_req", ba.sync_req_o, 1);
        `CHK("t1_busy",     ba.busy_o, 1);
        `CHK("t1_idx",      ba.sync_idx_o, 2);
        `CHK("t1_data",     ba.sync_data_o, 8'hA5);
        repeat (5) tick();
        `CHK("t1_hold", ba.sync_req_o, 1);
        ba.sync_ack_i = 1'b1;
        #1;
        `CHK("t1_ack", ba.ack_o, 4'b0100);
        tick();
        ba.sync_ack_i = 1'b0;
        ba.req_i = '0;
        #1;
        `CHK("t1_ack_pulse", ba.ack_o, 0);
        `CHK("t1_release",   ba.sync_req_o, 0);

        ba.req_i = 4'b1111;
        hs(3, 8'h33); hs(0, 8'h11); hs(1, 8'h22); hs(2, 8'hA5);
        ba.req_i = 4'b1000;
        hs(3, 8'h33);
        ba.req_i = 4'b1111;
        hs(0, 8'h11); hs(1, 8'h22); hs(2, 8'hA5); hs(3, 8'h33);

        ba.req_i = 4'b0010;
        tick();
        `CHK("drop_idx", ba.sync_idx_o, 1);
        ba.req_i = '0;
        ba.data_i[15:8] = 8'h77;
        tick(); tick();
        `CHK("drop_req_held", ba.sync_req_o, 1);
        `CHK("drop_data",     ba.sync_data_o, 8'h22);
        ba.sync_ack_i = 1'b1;
        #1;
        `CHK("drop_ack", ba.ack_o, 4'b0010);
        tick();
        ba.sync_ack_i = 1'b0;
        ba.data_i[15:8] = 8'h22;
        #1;

        ba.sync_ack_i = 1'b1;
        #1;
        `CHK("stray_ack", ba.ack_o, 0);
        tick();
        `CHK("stray_busy", ba.busy_o, 0);
        `CHK("stray_idx",  ba.sync_idx_o, 1);
        ba.sync_ack_i = 1'b0;

        ba.req_i = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            tick();
            `CHK("wd_err", ba.err_timeout_o, (c == 8));
            `CHK("wd_req", ba.sync_req_o, 1);
        end
        `CHK("wd_idx", ba.sync_idx_o, 0);
        ba.sync_ack_i = 1'b1;
        #1;
        `CHK("wd_late_ack", ba.ack_o, 4'b0001);
        tick();
        ba.sync_ack_i = 1'b0;
        ba.req_i = '0;
        #1;
        `CHK("wd_idle",   ba.busy_o, 0);
        `CHK("wd_sticky", ba.err_timeout_o, 1);

        bb.data_i = {8'hC3, 8'hB2, 8'hA1};
        bb.req_i  = 3'b100;
        tick();
        `CHK("w3_idx", bb.sync_idx_o, 2);
        bb.sync_ack_i = 1'b1;
        #1;
        `CHK("w3_ack", bb.ack_o, 3'b100);
        tick();
        bb.sync_ack_i = 1'b0;
        bb.req_i = 3'b111;
        tick();
        `CHK("w3_wrap_idx",  bb.sync_idx_o, 0);
        `CHK("w3_wrap_data", bb.sync_data_o, 8'hA1);
        `CHK("w3_no_wd",     bb.err_timeout_o, 0);
        bb.sync_ack_i = 1'b1;
        #1;
        `CHK("w3_ack0", bb.ack_o, 3'b001);
        tick();
        bb.sync_ack_i = 1'b0;
        bb.req_i = '0;

        ba.req_i = 4'b0010;
        tick();
        `CHK("ar_busy", ba.busy_o, 1);
        #2;
        ba.sync_ack_i = 1'b1;
        rst_n = 1'b0;
        #1;
        `CHK("ar_sync_req", ba.sync_req_o, 0);
        `CHK("ar_busy0",    ba.busy_o, 0);
        `CHK("ar_idx",      ba.sync_idx_o, 0);
        `CHK("ar_data",     ba.sync_data_o, 0);
        `CHK("ar_err",      ba.err_timeout_o, 0);
        `CHK("ar_ack",      ba.ack_o, 0);
        @(negedge clk);
        ba.sync_ack_i = 1'b0;
        rst_n = 1'b1;
        tick();
        `CHK("ar_regrant", ba.busy_o, 1);
        `CHK("ar_idx1",    ba.sync_idx_o, 1);
        `CHK("ar_data1",   ba.sync_data_o, 8'h22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
